// File: rtl/rtc_bus_bridge.sv
// PicoBlaze port-mapped bridge to a multiplexed address/data RTC bus.
// Commands are queued in a FIFO and each one runs an address phase, a gap and a data phase.
module rtc_bus_bridge #(
    parameter int         DATA_W     = 8,
    parameter logic [7:0] PORT_BASE  = 8'h10,
    parameter int         FIFO_DEPTH = 4,
    parameter int         T_SETUP    = 2,
    parameter int         T_PULSE    = 4,
    parameter int         T_HOLD     = 2,
    parameter int         T_GAP      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic [DATA_W-1:0] out_port,
    input  logic              write_strobe,
    input  logic              read_strobe,
    output logic [DATA_W-1:0] in_port,
    output logic              rtc_a_d,
    output logic              rtc_cs_n,
    output logic              rtc_rd_n,
    output logic              rtc_wr_n,
    output logic [DATA_W-1:0] rtc_ad_o,
    output logic              rtc_ad_oe,
    input  logic [DATA_W-1:0] rtc_ad_i,
    output logic              done_pulse
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 2 * DATA_W + 1;
    localparam int CNT_W   = 8;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

    localparam logic [7:0] P_ADDR   = PORT_BASE;
    localparam logic [7:0] P_WDATA  = PORT_BASE + 8'd1;
    localparam logic [7:0] P_CMD    = PORT_BASE + 8'd2;
    localparam logic [7:0] P_STATUS = PORT_BASE + 8'd3;
    localparam logic [7:0] P_RDATA  = PORT_BASE + 8'd4;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ADDR_SETUP = 4'd1;
    localparam logic [3:0] S_ADDR_PULSE = 4'd2;
    localparam logic [3:0] S_ADDR_HOLD  = 4'd3;
    localparam logic [3:0] S_GAP        = 4'd4;
    localparam logic [3:0] S_DATA_SETUP = 4'd5;
    localparam logic [3:0] S_DATA_PULSE = 4'd6;
    localparam logic [3:0] S_DATA_HOLD  = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    logic [3:0]         state, ns;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               pop;
    logic [DATA_W-1:0]  addr_q, wdata_q, rdata_q;
    logic               st_done, st_ovf, st_rdv;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]        wp, rp;
    logic               full, empty, busy;
    logic               cur_rd, nxt_rd;
    logic [DATA_W-1:0]  cur_addr, cur_wdata, nxt_addr, nxt_wdata;
    logic [ENTRY_W-1:0] head;
    logic               sel_addr, sel_wdata, sel_cmd, sel_status, cmd_push;
    logic [DATA_W-1:0]  status_v, rd_mux;
    logic               nx_a_d, nx_cs_n, nx_rd_n, nx_wr_n, nx_oe;
    logic [DATA_W-1:0]  nx_ad_o;
    logic               unused_read_strobe;

    assign unused_read_strobe = read_strobe;

    assign sel_addr   = write_strobe && (port_id == P_ADDR);
    assign sel_wdata  = write_strobe && (port_id == P_WDATA);
    assign sel_cmd    = write_strobe && (port_id == P_CMD);
    assign sel_status = write_strobe && (port_id == P_STATUS);

    assign empty    = (wp == rp);
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign busy     = (state != S_IDLE) || !empty;
    assign cmd_push = sel_cmd && !full;
    assign head     = fifo_mem[rp[AW-1:0]];

    assign status_v = {{(DATA_W-5){1'b0}}, st_rdv, st_ovf, full, busy, st_done};

    always_comb begin
        ns    = state;
        cnt_n = cnt;
        pop   = 1'b0;
        case (state)
            S_IDLE: if (!empty) begin
                pop = 1'b1; ns = S_ADDR_SETUP; cnt_n = LD_SETUP;
            end
            S_ADDR_SETUP: if (cnt == '0) begin ns = S_ADDR_PULSE; cnt_n = LD_PULSE; end
                          else cnt_n = cnt - 1'b1;
            S_ADDR_PULSE: if (cnt == '0) begin ns = S_ADDR_HOLD; cnt_n = LD_HOLD; end
                          else cnt_n = cnt - 1'b1;
            S_ADDR_HOLD:  if (cnt == '0) begin ns = S_GAP; cnt_n = LD_GAP; end
                          else cnt_n = cnt - 1'b1;
            S_GAP:        if (cnt == '0) begin ns = S_DATA_SETUP; cnt_n = LD_SETUP; end
                          else cnt_n = cnt - 1'b1;
            S_DATA_SETUP: if (cnt == '0) begin ns = S_DATA_PULSE; cnt_n = LD_PULSE; end
                          else cnt_n = cnt - 1'b1;
            S_DATA_PULSE: if (cnt == '0) begin ns = S_DATA_HOLD; cnt_n = LD_HOLD; end
                          else cnt_n = cnt - 1'b1;
            S_DATA_HOLD:  if (cnt == '0) begin ns = S_DONE; cnt_n = '0; end
                          else cnt_n = cnt - 1'b1;
            default:      begin ns = S_IDLE; cnt_n = '0; end
        endcase
    end

    // Bus outputs are decoded from the next state so they leave a flop with no decode glitches.
    assign {nxt_rd, nxt_addr, nxt_wdata} = pop ? head : {cur_rd, cur_addr, cur_wdata};

    always_comb begin
        nx_a_d  = 1'b1;
        nx_cs_n = 1'b1;
        nx_rd_n = 1'b1;
        nx_wr_n = 1'b1;
        nx_oe   = 1'b0;
        nx_ad_o = '0;
        case (ns)
            S_ADDR_SETUP, S_ADDR_PULSE, S_ADDR_HOLD: begin
                nx_a_d  = 1'b0;
                nx_cs_n = 1'b0;
                nx_oe   = 1'b1;
                nx_ad_o = nxt_addr;
                nx_wr_n = (ns != S_ADDR_PULSE);
            end
            S_DATA_SETUP, S_DATA_PULSE, S_DATA_HOLD: begin
                nx_cs_n = 1'b0;
                nx_oe   = !nxt_rd;
                nx_ad_o = nxt_rd ? '0 : nxt_wdata;
                nx_rd_n = !((ns == S_DATA_PULSE) && nxt_rd);
                nx_wr_n = !((ns == S_DATA_PULSE) && !nxt_rd);
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (port_id)
            P_STATUS: rd_mux = status_v;
            P_RDATA:  rd_mux = rdata_q;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cmd_push) fifo_mem[wp[AW-1:0]] <= {out_port[0], addr_q, wdata_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wp         <= '0;
            rp         <= '0;
            cur_rd     <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            st_done    <= 1'b0;
            st_ovf     <= 1'b0;
            st_rdv     <= 1'b0;
            in_port    <= '0;
            rtc_a_d    <= 1'b1;
            rtc_cs_n   <= 1'b1;
            rtc_rd_n   <= 1'b1;
            rtc_wr_n   <= 1'b1;
            rtc_ad_oe  <= 1'b0;
            rtc_ad_o   <= '0;
            done_pulse <= 1'b0;
        end else begin
            state <= ns;
            cnt   <= cnt_n;
            if (pop) begin
                cur_rd    <= nxt_rd;
                cur_addr  <= nxt_addr;
                cur_wdata <= nxt_wdata;
                rp        <= rp + 1'b1;
            end
            if (cmd_push)  wp      <= wp + 1'b1;
            if (sel_addr)  addr_q  <= out_port;
            if (sel_wdata) wdata_q <= out_port;
            if ((state == S_DATA_PULSE) && (cnt == '0) && cur_rd) rdata_q <= rtc_ad_i;
            // Sticky bits: a same-cycle set overrides the firmware clear.
            st_done <= (st_done & ~(sel_status & out_port[0])) | (state == S_DONE);
            st_ovf  <= (st_ovf  & ~(sel_status & out_port[3])) | (sel_cmd & full);
            st_rdv  <= (st_rdv  & ~(sel_status & out_port[4])) | ((state == S_DONE) & cur_rd);
            in_port    <= rd_mux;
            rtc_a_d    <= nx_a_d;
            rtc_cs_n   <= nx_cs_n;
            rtc_rd_n   <= nx_rd_n;
            rtc_wr_n   <= nx_wr_n;
            rtc_ad_oe  <= nx_oe;
            rtc_ad_o   <= nx_ad_o;
            done_pulse <= (state == S_DONE);
        end
    end
endmodule

// File: doc/rtc_bus_bridge.md
Name: rtc_bus_bridge

Overview:
- Port-mapped bridge between the PicoBlaze I/O bus and a multiplexed address/data parallel RTC bus (A/D select, active-low CS/RD/WR).
- Queues CPU-issued read/write transactions in a small FIFO and sequences each as an address phase plus a data phase, with parametrised timing.
- Exposes a sticky status register and a read-data register to firmware, and drives a registered in_port.
- Successor to the single-transaction RTC reader/writer: adds parametrised width and timing, command queueing, overflow detection and a fully defined in_port mux.

Parameters:
- DATA_W, 8: RTC bus and register width.
- PORT_BASE, 8'h10: base port_id. Offsets: +0 ADDR(W), +1 WDATA(W), +2 CMD(W), +3 STATUS(R/W), +4 RDATA(R).
- FIFO_DEPTH, 4: command queue depth; power of 2, at least 2.
- T_SETUP, 2: clk cycles of setup before the strobe; at least 1.
- T_PULSE, 4: clk cycles the strobe is held low; at least 1.
- T_HOLD, 2: clk cycles of hold after the strobe rises; at least 1.
- T_GAP, 2: clk cycles with CS high between the address and data phases; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- port_id  in  8  PicoBlaze port address.
- out_port  in  DATA_W  PicoBlaze write data.
- write_strobe  in  1  PicoBlaze write qualifier.
- read_strobe  in  1  PicoBlaze read qualifier (informational only; reads have no side effects).
- in_port  out  DATA_W  registered read mux to PicoBlaze.
- rtc_a_d  out  1  0 = address phase, 1 = data phase.
- rtc_cs_n  out  1  chip select, active low.
- rtc_rd_n  out  1  read strobe, active low.
- rtc_wr_n  out  1  write strobe, active low.
- rtc_ad_o  out  DATA_W  bus drive value.
- rtc_ad_oe  out  1  tristate enable (the top level builds the inout).
- rtc_ad_i  in  DATA_W  bus sample value.
- done_pulse  out  1  one-cycle pulse per completed transaction.

Behaviour:
- Reset values:
  - in_port = 0; rtc_cs_n = rtc_rd_n = rtc_wr_n = 1; rtc_a_d = 1; rtc_ad_oe = 0; rtc_ad_o = 0; done_pulse = 0.
  - FIFO emptied; ADDR, WDATA and RDATA registers = 0; all status bits = 0.
- Register writes (write_strobe = 1):
  - ADDR and WDATA are loaded from out_port.
  - CMD pushes {out_port[0], ADDR, WDATA} into the FIFO (cmd bit 1 = read, 0 = write).
  - CMD uses the ADDR/WDATA values registered before this edge.
- STATUS bits:
  - [0] done: sticky; set on the DONE state.
  - [1] busy: FSM not in IDLE, or FIFO not empty.
  - [2] fifo_full.
  - [3] overflow: sticky; set when CMD is written while the FIFO is full; that entry is dropped and the FIFO is unchanged.
  - [4] rd_valid: sticky; set when a read completes.
  - Upper bits read 0.
  - Writing STATUS clears each sticky bit whose out_port bit is 1.
  - If a set and a clear of the same bit occur in the same cycle, the set wins.
- in_port timing:
  - Registered one cycle after port_id: in_port at edge N+1 reflects port_id and register contents at edge N.
  - STATUS and RDATA ports return their values; any other port_id returns 0, never X.
- Pop rule: FSM in IDLE with FIFO non-empty → pop the head and enter ADDR_SETUP on the same edge. With an empty FIFO, a CMD written at edge E brings rtc_cs_n low from edge E+1.
- FSM, one down-counter per timed state:
  - ADDR_SETUP (T_SETUP): a_d = 0, cs_n = 0, oe = 1, ad_o = addr.
  - ADDR_PULSE (T_PULSE): same as ADDR_SETUP, plus wr_n = 0.
  - ADDR_HOLD (T_HOLD): wr_n = 1; a_d, cs_n and oe unchanged.
  - GAP (T_GAP): cs_n = 1, oe = 0, a_d = 1.
  - DATA_SETUP (T_SETUP): a_d = 1, cs_n = 0. For a write, oe = 1 and ad_o = wdata; for a read, oe = 0.
  - DATA_PULSE (T_PULSE): rd_n = 0 for a read, wr_n = 0 for a write. A read samples rtc_ad_i into RDATA at the edge that leaves DATA_PULSE.
  - DATA_HOLD (T_HOLD): strobes high; cs_n and oe unchanged.
  - DONE (1 cycle): bus idle values, done_pulse = 1, done is set (and rd_valid for a read), then return to IDLE.
- Transaction length: IDLE exit to IDLE return is 2*(T_SETUP + T_PULSE + T_HOLD) + T_GAP + 1 cycles (19 with defaults).
- Back-to-back commands: the next FIFO entry pops in the cycle after DONE.
- All bus outputs are registered and glitch-free. rd_n and wr_n are never low simultaneously. oe is never 1 while rd_n = 0.
- Asserting reset mid-transaction immediately forces bus outputs to their idle values, the FSM to IDLE and the FIFO to empty; no partial RDATA update occurs.

Test Plan:
- Reset, then write ADDR = 0x21, WDATA = 0x5A, CMD = 0x00. Required:
  - An address phase drives ad_o = 0x21 with a_d = 0 and wr_n low for 4 cycles.
  - After 2 gap cycles, the data phase drives 0x5A with a_d = 1 and wr_n low for 4 cycles.
  - done_pulse fires 19 cycles after cs_n first falls.
  - A STATUS read returns 0x01.
- Read: ADDR = 0x22, CMD = 0x01, bench drives rtc_ad_i = 0xC3 during DATA_PULSE. Required:
  - oe = 0 throughout the data phase.
  - A RDATA read returns 0xC3; STATUS returns 0x11.
- Sticky clear and collision: write STATUS = 0x01 in the same cycle as a DONE → done remains 1. A later STATUS = 0x11 write → STATUS reads 0x00.
- Overflow: issue 5 CMD writes back-to-back while the first transaction is active (depth 4). Required:
  - STATUS reads 0x0E (busy, full, overflow).
  - Exactly 5 transactions complete: the active one plus 4 queued.
  - The sixth CMD is lost.
- Reset mid-DATA_PULSE of a read: assert reset asynchronously. Required:
  - cs_n, rd_n and wr_n are high and oe = 0 before the next clk edge.
  - RDATA = 0x00 and STATUS = 0x00 after release.
- Unmapped read: port_id = 0x7F → in_port = 0x00 on the next cycle. No bus activity and no status change.
